// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants, payload field offsets and the skid occupancy states
// for the pipe_stage_skid inter-stage register.
package pipe_stage_skid_pkg;

  localparam logic [31:0] NopInst      = 32'h0000_0013;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        RstEnable    = 1'b0;
  localparam logic        WriteDisable = 1'b0;

  // Payload packing offsets (LSB, width) so producer and consumer stages agree
  localparam int unsigned PayRdLsb      = 0;
  localparam int unsigned PayRdW        = 5;
  localparam int unsigned PayUopLsb     = 5;
  localparam int unsigned PayUopW       = 8;
  localparam int unsigned PayMemAddrLsb = 13;
  localparam int unsigned PayMemAddrW   = 32;
  localparam int unsigned PayMemDataLsb = 45;
  localparam int unsigned PayMemDataW   = 32;
  localparam int unsigned PayCsrLsb     = 77;
  localparam int unsigned PayCsrW       = 12;
  localparam int unsigned PayExcLsb     = 89;
  localparam int unsigned PayExcW       = 5;

  typedef enum logic [1:0] {
    SkEmpty = 2'd0,
    SkOne   = 2'd1,
    SkFull  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_br_attr.sv
// Branch-slot PC attribution: while a branch is outstanding, accepted beats
// are tagged with the branch PC until the first target-fetched beat passes.
module pipe_br_attr
  import pipe_stage_skid_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            flush,
  input  logic            acc,
  input  logic [PC_W-1:0] in_pc,
  input  logic            branch_tag,
  input  logic            slot_end,
  output logic [PC_W-1:0] attr_pc
);

  logic            br_active;
  logic [PC_W-1:0] br_pc;

  assign attr_pc = br_active ? br_pc : in_pc;

  // A beat with both tag and slot_end is a self-loop branch: the tag wins.
  always_ff @(posedge clk) begin
    if (n_rst == RstEnable || flush) begin
      br_active <= 1'b0;
      br_pc     <= '0;
    end else if (acc) begin
      if (branch_tag) begin
        br_active <= 1'b1;
        br_pc     <= in_pc;
      end else if (br_active && slot_end) begin
        br_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline register with a registered in_ready and a skid entry.
// Define PIPE_STAGE_ZERO_BUBBLE_EN to force bubble encoding on the outputs when invalid.
//
//  state   | meaning
//  SkEmpty | nothing held, ready for input
//  SkOne   | main register holds the output beat
//  SkFull  | main and skid both hold beats, in_ready low
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int              DATA_W   = 128,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] NOP_INST = PC_W'(NopInst),
  parameter bit              BR_TRACK = 1'b1
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [PC_W-1:0]   in_inst_i,
  input  logic              in_branch_tag_i,
  input  logic              in_slot_end_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [PC_W-1:0]   out_inst_o,
  output logic [DATA_W-1:0] out_data_o
);

  skid_state_e       state, state_nxt;
  logic              acc, pop;
  logic              load_main_in, load_main_skid, load_skid;
  logic [PC_W-1:0]   stored_pc;
  logic [PC_W-1:0]   skid_pc, skid_inst;
  logic [DATA_W-1:0] skid_data;

  // A beat offered alongside flush is discarded, so it never counts as accepted.
  assign acc         = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i;
  assign out_valid_o = (state != SkEmpty);

  generate
    if (BR_TRACK) begin : g_br
      pipe_br_attr #(.PC_W(PC_W)) u_br_attr (
        .clk        (clk_i),
        .n_rst      (n_rst_i),
        .flush      (flush_i),
        .acc        (acc),
        .in_pc      (in_pc_i),
        .branch_tag (in_branch_tag_i),
        .slot_end   (in_slot_end_i),
        .attr_pc    (stored_pc)
      );
    end else begin : g_no_br
      assign stored_pc = in_pc_i;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (n_rst_i == RstEnable) state <= SkEmpty;
    else                      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      SkEmpty: begin
        if (acc) begin
          state_nxt    = SkOne;
          load_main_in = 1'b1;
        end
      end
      SkOne: begin
        if (acc && !pop) begin
          state_nxt = SkFull;
          load_skid = 1'b1;
        end else if (acc && pop) begin
          load_main_in = 1'b1;
        end else if (pop) begin
          state_nxt = SkEmpty;
        end
      end
      SkFull: begin
        if (pop) begin
          state_nxt      = SkOne;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = SkEmpty;
    endcase
    if (flush_i) begin
      state_nxt      = SkEmpty;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (n_rst_i == RstEnable) begin
      in_ready_o <= 1'b1;
      out_pc_o   <= '0;
      out_inst_o <= NOP_INST;
      out_data_o <= '0;
      skid_pc    <= '0;
      skid_inst  <= NOP_INST;
      skid_data  <= '0;
    end else begin
      in_ready_o <= (state_nxt != SkFull);
      if (load_main_in) begin
        out_pc_o   <= stored_pc;
        out_inst_o <= in_inst_i;
        out_data_o <= in_data_i;
      end else if (load_main_skid) begin
        out_pc_o   <= skid_pc;
        out_inst_o <= skid_inst;
        out_data_o <= skid_data;
      end
`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
      else if (state_nxt == SkEmpty) begin
        out_pc_o   <= '0;
        out_inst_o <= NOP_INST;
        out_data_o <= '0;
      end
`endif
      if (load_skid) begin
        skid_pc   <= stored_pc;
        skid_inst <= in_inst_i;
        skid_data <= in_data_i;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (default parameters).
// Honours PIPE_STAGE_ZERO_BUBBLE_EN for the bubble-encoding checks.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc, in_inst;
  logic         in_tag, in_se;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc, out_inst;
  logic [127:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_skid dut (
    .clk_i           (clk),
    .n_rst_i         (n_rst),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_pc_i         (in_pc),
    .in_inst_i       (in_inst),
    .in_branch_tag_i (in_tag),
    .in_slot_end_i   (in_se),
    .in_data_i       (in_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_pc_o        (out_pc),
    .out_inst_o      (out_inst),
    .out_data_o      (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc + 32'h0010_0000;
  endfunction

  function automatic logic [127:0] data_of(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, pc, ~pc, pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic tag, input logic se,
                      input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    in_data   = data_of(pc);
    in_tag    = tag;
    in_se     = se;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Checks a valid output beat: attributed pc plus inst/data of the originating beat.
  task automatic chk_beat(input string tag, input logic [31:0] exp_pc, input logic [31:0] src_pc);
    chk({tag, ".valid"}, 128'(out_valid), 128'(1'b1));
    chk({tag, ".pc"},    128'(out_pc),    128'(exp_pc));
    chk({tag, ".inst"},  128'(out_inst),  128'(inst_of(src_pc)));
    chk({tag, ".data"},  out_data,        data_of(src_pc));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 128'(out_valid), 128'(1'b0));
    chk({tag, ".ready"}, 128'(in_ready),  128'(1'b1));
    chk({tag, ".pc"},    128'(out_pc),    128'(0));
    chk({tag, ".inst"},  128'(out_inst),  128'(32'h0000_0013));
    chk({tag, ".data"},  out_data,        128'(0));
  endtask

  initial begin
    n_rst = 1'b0;
    step(0, 32'h0, 0, 0, 1, 0);
    step(0, 32'h0, 0, 0, 1, 0);
    chk_reset_vals("reset");
    n_rst = 1'b1;

    // throughput: one beat per cycle, one cycle latency
    step(1, 32'h100, 0, 0, 1, 0); chk_beat("tp0", 32'h100, 32'h100); chk("tp0.rdy", 128'(in_ready), 128'(1'b1));
    step(1, 32'h104, 0, 0, 1, 0); chk_beat("tp1", 32'h104, 32'h104); chk("tp1.rdy", 128'(in_ready), 128'(1'b1));
    step(1, 32'h108, 0, 0, 1, 0); chk_beat("tp2", 32'h108, 32'h108); chk("tp2.rdy", 128'(in_ready), 128'(1'b1));
    step(1, 32'h10C, 0, 0, 1, 0); chk_beat("tp3", 32'h10C, 32'h10C); chk("tp3.rdy", 128'(in_ready), 128'(1'b1));
    step(0, 32'h0,   0, 0, 1, 0); chk("tp.drain", 128'(out_valid), 128'(1'b0));
`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
    chk("tp.bub_inst", 128'(out_inst), 128'(32'h0000_0013));
    chk("tp.bub_pc",   128'(out_pc),   128'(0));
`else
    chk("tp.hold_pc",  128'(out_pc),   128'(32'h10C));
`endif

    // backpressure fills the skid; held outputs stay stable
    step(1, 32'h200, 0, 0, 0, 0); chk_beat("bp0", 32'h200, 32'h200); chk("bp0.rdy", 128'(in_ready), 128'(1'b1));
    step(1, 32'h204, 0, 0, 0, 0); chk_beat("bp1", 32'h200, 32'h200); chk("bp1.rdy", 128'(in_ready), 128'(1'b0));
    step(1, 32'h208, 0, 0, 0, 0); chk_beat("bp2", 32'h200, 32'h200); chk("bp2.rdy", 128'(in_ready), 128'(1'b0));
    step(0, 32'h0,   0, 0, 1, 0); chk_beat("bp3", 32'h204, 32'h204); chk("bp3.rdy", 128'(in_ready), 128'(1'b1));
    step(0, 32'h0,   0, 0, 1, 0); chk("bp.drain", 128'(out_valid), 128'(1'b0));

    // branch attribution
    step(1, 32'h300, 1, 0, 1, 0); chk_beat("br0", 32'h300, 32'h300);
    step(1, 32'h400, 0, 0, 1, 0); chk_beat("br1", 32'h300, 32'h400);
    step(1, 32'h500, 0, 1, 1, 0); chk_beat("br2", 32'h300, 32'h500);
    step(1, 32'h504, 0, 0, 1, 0); chk_beat("br3", 32'h504, 32'h504);
    step(0, 32'h0,   0, 0, 1, 0); chk("br.drain", 128'(out_valid), 128'(1'b0));

    // self-loop branch: tag wins over slot_end, tracking stays on 0x600
    step(1, 32'h600, 1, 1, 1, 0); chk_beat("sl0", 32'h600, 32'h600);
    step(1, 32'h600, 1, 1, 1, 0); chk_beat("sl1", 32'h600, 32'h600);
    step(1, 32'h600, 1, 1, 1, 0); chk_beat("sl2", 32'h600, 32'h600);
    step(1, 32'h604, 0, 0, 1, 0); chk_beat("sl3", 32'h600, 32'h604);
    step(1, 32'h608, 0, 1, 1, 0); chk_beat("sl4", 32'h600, 32'h608);
    step(1, 32'h60C, 0, 0, 1, 0); chk_beat("sl5", 32'h60C, 32'h60C);
    step(0, 32'h0,   0, 0, 1, 0); chk("sl.drain", 128'(out_valid), 128'(1'b0));

    // flush while FULL with a beat offered; tracking state must be dropped too
    step(1, 32'h700, 1, 0, 0, 0); chk_beat("fl0", 32'h700, 32'h700);
    step(1, 32'h704, 0, 0, 0, 0); chk("fl1.rdy", 128'(in_ready), 128'(1'b0));
    step(1, 32'h708, 0, 0, 0, 1);
    chk("fl2.valid", 128'(out_valid), 128'(1'b0));
    chk("fl2.rdy",   128'(in_ready),  128'(1'b1));
`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
    chk("fl2.inst",  128'(out_inst),  128'(32'h0000_0013));
    chk("fl2.pc",    128'(out_pc),    128'(0));
`endif
    step(0, 32'h0,   0, 0, 1, 0); chk("fl3.valid", 128'(out_valid), 128'(1'b0));
    step(1, 32'h710, 0, 0, 1, 1); chk("fl4.valid", 128'(out_valid), 128'(1'b0));
    step(0, 32'h0,   0, 0, 1, 0); chk("fl5.valid", 128'(out_valid), 128'(1'b0));
    step(1, 32'h7F0, 0, 0, 1, 0); chk_beat("fl6", 32'h7F0, 32'h7F0);
    step(0, 32'h0,   0, 0, 1, 0); chk("fl.drain", 128'(out_valid), 128'(1'b0));

    // reset while FULL with branch tracking active
    step(1, 32'h780, 1, 0, 0, 0);
    step(1, 32'h784, 0, 0, 0, 0); chk("rs0.rdy", 128'(in_ready), 128'(1'b0));
    n_rst = 1'b0;
    step(0, 32'h0, 0, 0, 0, 0);
    chk_reset_vals("rs1");
    n_rst = 1'b1;
    step(1, 32'h800, 0, 0, 1, 0); chk_beat("rs2", 32'h800, 32'h800);
    step(0, 32'h0,   0, 0, 1, 0); chk("rs3.valid", 128'(out_valid), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
